// File: rtl/soc_system_led_driver.sv
// LED pattern engine driven by a PIO control word: static, blink, chase and bounce
// modes, with a tick/rate step generator and a 16-level PWM brightness gate.
module soc_system_led_driver #(
  parameter int NUM_LEDS = 10,
  parameter int TICK_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         ctrl,
  output logic [NUM_LEDS-1:0] led,
  output logic                frame_tick
);

  localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int POSW = $clog2(NUM_LEDS);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [POSW-1:0] POS_LAST  = POSW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    ST_STATIC = 2'b00,
    ST_BLINK  = 2'b01,
    ST_CHASE  = 2'b10,
    ST_BOUNCE = 2'b11
  } state_t;

  logic [31:0]         ctrl_q;
  logic [PW-1:0]       presc;
  logic [7:0]          rate_cnt, rate_cnt_n;
  logic [3:0]          pwm_cnt;
  state_t              state, state_n;
  logic [NUM_LEDS-1:0] pattern, pattern_n, chase_pat, chase_n, mask_d;
  logic                phase, phase_n, dir, dir_n;
  logic [POSW-1:0]     pos, pos_n;

  logic [NUM_LEDS-1:0] mask;
  state_t              mode;
  logic [3:0]          duty;
  logic [7:0]          rate;
  logic                tick, step, pwm_on, mode_chg;
  logic                unused;

  assign mask     = ctrl_q[NUM_LEDS-1:0];
  assign mode     = state_t'(ctrl_q[17:16]);
  assign duty     = ctrl_q[23:20];
  assign rate     = ctrl_q[31:24];
  assign unused   = ^{ctrl_q[19:18], ctrl_q[15:0]};
  assign tick     = (presc == TICK_LAST);
  assign step     = tick && (rate_cnt == rate);
  assign pwm_on   = (pwm_cnt <= duty);
  assign mode_chg = (mode != state);

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    chase_n    = chase_pat;
    pos_n      = pos;
    dir_n      = dir;
    rate_cnt_n = rate_cnt;
    pattern_n  = '0;
    if (tick) rate_cnt_n = step ? 8'd0 : rate_cnt + 8'd1;
    // Mode entry re-initialises every walker and swallows a coincident step.
    if (mode_chg) begin
      state_n    = mode;
      rate_cnt_n = 8'd0;
      phase_n    = 1'b1;
      chase_n    = mask;
      pos_n      = '0;
      dir_n      = 1'b1;
    end else begin
      case (state)
        ST_BLINK: if (step) phase_n = ~phase;
        ST_CHASE: begin
          if (mask != mask_d)  chase_n = mask;
          else if (step)       chase_n = {chase_pat[NUM_LEDS-2:0], chase_pat[NUM_LEDS-1]};
        end
        ST_BOUNCE: if (step) begin
          if (dir) begin
            if (pos == POS_LAST) begin pos_n = pos - 1'b1; dir_n = 1'b0; end
            else                       pos_n = pos + 1'b1;
          end else begin
            if (pos == '0)       begin pos_n = POSW'(1); dir_n = 1'b1; end
            else                       pos_n = pos - 1'b1;
          end
        end
        default: ;
      endcase
    end
    case (state)
      ST_STATIC: pattern_n = mask;
      ST_BLINK:  pattern_n = phase ? mask : '0;
      ST_CHASE:  pattern_n = chase_pat;
      ST_BOUNCE: pattern_n = NUM_LEDS'(1) << pos;
      default:   pattern_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      presc      <= '0;
      rate_cnt   <= '0;
      pwm_cnt    <= '0;
      state      <= ST_STATIC;
      pattern    <= '0;
      chase_pat  <= '0;
      mask_d     <= '0;
      phase      <= 1'b1;
      pos        <= '0;
      dir        <= 1'b1;
      led        <= '0;
      frame_tick <= 1'b0;
    end else begin
      ctrl_q     <= ctrl;
      presc      <= tick ? '0 : presc + 1'b1;
      rate_cnt   <= rate_cnt_n;
      pwm_cnt    <= pwm_cnt + 4'd1;
      state      <= state_n;
      pattern    <= pattern_n;
      chase_pat  <= chase_n;
      mask_d     <= mask;
      phase      <= phase_n;
      pos        <= pos_n;
      dir        <= dir_n;
      led        <= pattern & {NUM_LEDS{pwm_on}};
      frame_tick <= step;
    end
  end

endmodule

// File: tb/tb_soc_system_led_driver.sv
// Directed bench for soc_system_led_driver (NUM_LEDS=10, TICK_DIV=4); edges are
// counted from the last reset edge and outputs are sampled on the falling edge.
module tb_soc_system_led_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ctrl = '0;
  logic [9:0]  led;
  logic        frame_tick;
  int          checks = 0;
  int          errors = 0;

  soc_system_led_driver #(.NUM_LEDS(10), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .ctrl(ctrl), .led(led), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] c);
    reset = 1'b1;
    ctrl  = '0;
    adv();
    adv();
    reset = 1'b0;
    ctrl  = c;
  endtask

  initial begin
    int lit, other, e, p, d;
    logic [31:0] exp_led;

    // Reset state, then STATIC 0x2A5 at full duty: 3-edge latency
    reset = 1'b1;
    adv();
    adv();
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_ft", 32'(frame_tick), 32'h0);
    reset = 1'b0;
    ctrl  = 32'h00F0_02A5;
    adv(); chk("static_e1", 32'(led), 32'h0);
    adv(); chk("static_e2", 32'(led), 32'h0);
    adv(); chk("static_e3", 32'(led), 32'h2A5);
    repeat (5) begin adv(); chk("static_hold", 32'(led), 32'h2A5); end

    // STATIC 0x3FF at duty 3: lit 4 of every 16 cycles
    ctrl = 32'h0030_03FF;
    repeat (4) adv();
    lit = 0; other = 0;
    repeat (16) begin
      adv();
      if (led == 10'h3FF) lit++;
      else if (led != 10'h000) other++;
    end
    chk("pwm_lit", 32'(lit), 32'd4);
    chk("pwm_other", 32'(other), 32'd0);

    // BLINK 0x0F0 rate 1: 8-cycle half periods, frame_tick every 8
    do_reset(32'h01F1_00F0);
    for (int k = 1; k <= 33; k++) begin
      adv();
      if (k < 3) exp_led = 32'h0;
      else       exp_led = ((((k - 2) / 8) % 2) == 0) ? 32'h0F0 : 32'h0;
      chk("blink_led", 32'(led), exp_led);
      chk("blink_ft", 32'(frame_tick), (k >= 8 && (k % 8) == 0) ? 32'h1 : 32'h0);
    end

    // CHASE 0x201 rate 0, mask reload mid-run, then one-cycle reset
    do_reset(32'h00F2_0201);
    for (int k = 1; k <= 23; k++) begin
      adv();
      case (k)
        3:  chk("chase_e3", 32'(led), 32'h201);
        4:  chk("chase_ft4", 32'(frame_tick), 32'h1);
        5:  begin chk("chase_e5", 32'(led), 32'h201); chk("chase_ft5", 32'(frame_tick), 32'h0); end
        6:  chk("chase_e6", 32'(led), 32'h003);
        9:  chk("chase_e9", 32'(led), 32'h003);
        10: chk("chase_e10", 32'(led), 32'h006);
        14: chk("chase_e14", 32'(led), 32'h00C);
        19: chk("reload_e19", 32'(led), 32'h001);
        21: chk("reload_e21", 32'(led), 32'h001);
        22: chk("reload_e22", 32'(led), 32'h002);
        default: ;
      endcase
      if (k == 15) ctrl = 32'h00F2_0001;
    end
    reset = 1'b1;
    adv();
    chk("midrst_led", 32'(led), 32'h0);
    chk("midrst_ft", 32'(frame_tick), 32'h0);
    reset = 1'b0;
    adv(); chk("post_ft1", 32'(frame_tick), 32'h0); chk("post_led1", 32'(led), 32'h0);
    adv(); chk("post_ft2", 32'(frame_tick), 32'h0); chk("post_led2", 32'(led), 32'h0);
    adv(); chk("post_ft3", 32'(frame_tick), 32'h0); chk("post_led3", 32'(led), 32'h001);
    adv(); chk("post_ft4", 32'(frame_tick), 32'h1);

    // BOUNCE rate 0: position walk 0..9..0,1 with no repeat at the ends
    do_reset(32'h00F3_0000);
    e = 0; p = 0; d = 1;
    for (int i = 0; i < 20; i++) begin
      while (e < 4 * i + 5) begin adv(); e++; end
      chk("bounce_pos", 32'(led), 32'h1 << p);
      if (d == 1) begin
        if (p == 9) begin p = 8; d = 0; end
        else p++;
      end else begin
        if (p == 0) begin p = 1; d = 1; end
        else p--;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
